rcvbuf: RTL and testbench

- Receive buffer directly downstream of the serial line receiver.
- Captures each byte the receiver presents with its one-cycle "full" pulse and queues it in a small FIFO.
- Exposes the FIFO to the CPU bus as a two-register device (status/control, data), with sticky overrun detection and a receive interrupt.
- Decouples software read latency from line timing so back-to-back characters are not lost.

---
 rtl/rcvbuf_if.sv | 30 +++
 rtl/rcvbuf.sv | 109 ++++++++++
 tb/tb_rcvbuf.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rcvbuf_if.sv
// rtl/rcvbuf_if.sv - receiver and CPU bus signal bundle for rcvbuf
//
// Purpose : groups the receiver byte handshake and the two-register CPU bus
//           of the receive buffer into one interface.
// Signals : rcv_full/rcv_data  byte-valid pulse and byte from the serial receiver
//           en/wr/addr/data_in bus access strobe, direction, register select, write data
//           data_out/wt/irq    bus read data, bus wait (always 0), receive interrupt
// Modports: master - receiver + CPU side (drives stimulus, observes outputs)
//           slave  - rcvbuf side
interface rcvbuf_if;
   logic        rcv_full;
   logic [7:0]  rcv_data;
   logic        en;
   logic        wr;
   logic        addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        wt;
   logic        irq;

   modport master (
      output rcv_full, rcv_data, en, wr, addr, data_in,
      input  data_out, wt, irq
   );

   modport slave (
      input  rcv_full, rcv_data, en, wr, addr, data_in,
      output data_out, wt, irq
   );
endinterface

// File: rtl/rcvbuf.sv
// rtl/rcvbuf.sv - receive byte FIFO with status/control and data registers
//
// Purpose : queues bytes from the serial receiver in a 2^AW x 8 circular
//           buffer and exposes them as a two-register bus device with sticky
//           overrun detection and a registered receive interrupt.
// Ports   : clk      system clock, rising edge
//           reset_n  asynchronous active-low reset
//           bus      rcvbuf_if.slave (rcv_full, rcv_data, en, wr, addr,
//                    data_in, data_out, wt, irq)
// Option  : RCVBUF_OVERRUN_IRQ_EN - when defined, a pending overrun also
//           raises irq (irq = ie & (ready | overrun)); otherwise
//           irq = ie & ready.
module rcvbuf #(
   parameter int AW = 4
) (
   input logic     clk,
   input logic     reset_n,
   rcvbuf_if.slave bus
);
   localparam int DEPTH = 1 << AW;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ie_q, ie_d;
   logic          ovr_q, ovr_d;
   logic          irq_q, irq_d;

   logic          empty, fifofull;
   logic          pop, push, overflow, ctrl_wr;
   logic [31:0]   status;

   assign empty    = (count_q == '0);
   assign fifofull = (count_q == (AW+1)'(DEPTH));

   assign pop      = bus.en & ~bus.wr & bus.addr & ~empty;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
   assign push     = bus.rcv_full & (~fifofull | pop);
   assign overflow = bus.rcv_full & fifofull & ~pop;
   assign ctrl_wr  = bus.en & bus.wr & ~bus.addr;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ie_d     = ie_q;
      ovr_d    = ovr_q;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;

      if (ctrl_wr) ie_d = bus.data_in[1];
      // Clear first so that an overflow in the same cycle wins.
      if (ctrl_wr && bus.data_in[2]) ovr_d = 1'b0;
      if (overflow)                  ovr_d = 1'b1;

`ifdef RCVBUF_OVERRUN_IRQ_EN
      irq_d = ie_q & (~empty | ovr_q);
`else
      irq_d = ie_q & ~empty;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ie_q     <= 1'b0;
         ovr_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ie_q     <= ie_d;
         ovr_q    <= ovr_d;
         irq_q    <= irq_d;
      end
   end

   // Storage has no reset; contents are only observable through the pointers.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.rcv_data;
   end

   always_comb begin
      status              = '0;
      status[0]           = ~empty;
      status[1]           = ie_q;
      status[2]           = ovr_q;
      status[8 +: AW + 1] = count_q;
   end

   always_comb begin
      bus.data_out = '0;
      if (bus.en && !bus.wr) begin
         if (!bus.addr)   bus.data_out = status;
         else if (!empty) bus.data_out = {24'h0, mem_q[rd_ptr_q]};
      end
   end

   assign bus.wt  = 1'b0;
   assign bus.irq = irq_q;
endmodule

// File: tb/tb_rcvbuf.sv
// tb/tb_rcvbuf.sv - scoreboard bench for rcvbuf
module tb_rcvbuf;
   logic clk = 1'b0;
   logic reset_n;

   rcvbuf_if bus ();

   rcvbuf #(.AW(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

`ifdef RCVBUF_OVERRUN_IRQ_EN
   localparam bit OVR_IRQ = 1'b1;
`else
   localparam bit OVR_IRQ = 1'b0;
`endif

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] exp_q[$];
   bit         m_ovr = 1'b0;
   bit         m_ie  = 1'b0;

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s        = '0;
      s[0]     = (exp_q.size() != 0);
      s[1]     = m_ie;
      s[2]     = m_ovr;
      s[12:8]  = 5'(exp_q.size());
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.en       = 1'b0;
      bus.wr       = 1'b0;
      bus.addr     = 1'b0;
      bus.data_in  = '0;
      bus.rcv_full = 1'b0;
      bus.rcv_data = '0;
   endtask

   task automatic rd(input logic a, output logic [31:0] d);
      bus.en   = 1'b1;
      bus.wr   = 1'b0;
      bus.addr = a;
      #1 d = bus.data_out;
      tick();
      bus.en = 1'b0;
   endtask

   task automatic wr_ctrl(input logic [31:0] v);
      bus.en      = 1'b1;
      bus.wr      = 1'b1;
      bus.addr    = 1'b0;
      bus.data_in = v;
      m_ie = v[1];
      if (v[2]) m_ovr = 1'b0;
      tick();
      idle();
   endtask

   task automatic push_byte(input logic [7:0] b);
      bus.rcv_full = 1'b1;
      bus.rcv_data = b;
      if (exp_q.size() < 16) exp_q.push_back(b);
      else m_ovr = 1'b1;
      tick();
      bus.rcv_full = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d, e;
      reset_n = 1'b0;
      idle();
      exp_q.delete();
      m_ie = 0; m_ovr = 0;
      tick(); tick();
      bus.en = 1'b1; bus.addr = 1'b0;
      #1;
      vectors++; if (bus.data_out !== 32'h0) begin miscompares++; $display("FAIL reset_status: got %h want %h", bus.data_out, 32'h0); end
      vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
      vectors++; if (bus.wt !== 1'b0) begin miscompares++; $display("FAIL reset_wt: got %b want 0", bus.wt); end
      bus.en = 1'b0;
      reset_n = 1'b1;
      tick();
      rd(1'b0, d); e = exp_status();
      vectors++; if (d !== e) begin miscompares++; $display("FAIL post_reset_status: got %h want %h", d, e); end
      rd(1'b1, d);
      vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL post_reset_data: got %h want %h", d, 32'h0); end
   endtask

   task automatic test_single();
      logic [31:0] d, e;
      push_byte(8'h41);
      rd(1'b0, d); e = exp_status();
      vectors++; if (d !== e || d !== 32'h101) begin miscompares++; $display("FAIL single_status: got %h want %h", d, 32'h101); end
      rd(1'b1, d); e = {24'h0, exp_q.pop_front()};
      vectors++; if (d !== e) begin miscompares++; $display("FAIL single_data: got %h want %h", d, e); end
      rd(1'b0, d);
      vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL single_status_after: got %h want %h", d, 32'h0); end
   endtask

   task automatic test_fill_overflow();
      logic [31:0] d, e;
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      push_byte(8'hFF);
      rd(1'b0, d); e = exp_status();
      vectors++; if (d !== e || d !== 32'h1005) begin miscompares++; $display("FAIL fill_status: got %h want %h", d, 32'h1005); end
      for (int i = 0; i < 16; i++) begin
         rd(1'b1, d); e = {24'h0, exp_q.pop_front()};
         vectors++; if (d !== e) begin miscompares++; $display("FAIL fill_data[%0d]: got %h want %h", i, d, e); end
      end
      rd(1'b0, d); e = exp_status();
      vectors++; if (d !== e) begin miscompares++; $display("FAIL drained_status: got %h want %h", d, e); end
      wr_ctrl(32'h4);
      rd(1'b0, d);
      vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL ovr_clear: got %h want %h", d, 32'h0); end
   endtask

   task automatic test_full_simul();
      logic [31:0] d, e;
      for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
      bus.en = 1'b1; bus.wr = 1'b0; bus.addr = 1'b1;
      bus.rcv_full = 1'b1; bus.rcv_data = 8'hAA;
      #1 d = bus.data_out;
      e = {24'h0, exp_q.pop_front()};
      exp_q.push_back(8'hAA);
      tick();
      idle();
      vectors++; if (d !== e) begin miscompares++; $display("FAIL simul_head: got %h want %h", d, e); end
      rd(1'b0, d); e = exp_status();
      vectors++; if (d !== e || d !== 32'h1001) begin miscompares++; $display("FAIL simul_status: got %h want %h", d, 32'h1001); end
      for (int i = 0; i < 16; i++) begin
         rd(1'b1, d); e = {24'h0, exp_q.pop_front()};
         vectors++; if (d !== e) begin miscompares++; $display("FAIL simul_data[%0d]: got %h want %h", i, d, e); end
      end
      vectors++; if (d !== 32'hAA) begin miscompares++; $display("FAIL simul_last: got %h want %h", d, 32'hAA); end
   endtask

   task automatic test_irq();
      logic [31:0] d, e;
      wr_ctrl(32'h2);
      vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL irq_idle: got %b want 0", bus.irq); end
      push_byte(8'h77);
      vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL irq_early: got %b want 0", bus.irq); end
      tick();
      vectors++; if (bus.irq !== 1'b1) begin miscompares++; $display("FAIL irq_set: got %b want 1", bus.irq); end
      rd(1'b1, d); e = {24'h0, exp_q.pop_front()};
      vectors++; if (d !== e) begin miscompares++; $display("FAIL irq_data: got %h want %h", d, e); end
      tick();
      vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear: got %b want 0", bus.irq); end
      rd(1'b1, d);
      vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL empty_read: got %h want %h", d, 32'h0); end
      rd(1'b0, d); e = exp_status();
      vectors++; if (d !== e || d !== 32'h2) begin miscompares++; $display("FAIL empty_status: got %h want %h", d, 32'h2); end
   endtask

   task automatic test_overrun();
      logic [31:0] d, e;
      logic        ei;
      for (int i = 0; i < 16; i++) push_byte(8'h30 + 8'(i));
      push_byte(8'hEE);
      // W1C write of overrun coincident with another overflow: set wins.
      bus.en = 1'b1; bus.wr = 1'b1; bus.addr = 1'b0; bus.data_in = 32'h4;
      bus.rcv_full = 1'b1; bus.rcv_data = 8'hBB;
      m_ie = 1'b0; m_ovr = 1'b1;
      tick();
      idle();
      rd(1'b0, d); e = exp_status();
      vectors++; if (d !== e || d !== 32'h1005) begin miscompares++; $display("FAIL ovr_set_wins: got %h want %h", d, 32'h1005); end
      for (int i = 0; i < 16; i++) begin
         rd(1'b1, d); e = {24'h0, exp_q.pop_front()};
         vectors++; if (d !== e) begin miscompares++; $display("FAIL ovr_data[%0d]: got %h want %h", i, d, e); end
      end
      wr_ctrl(32'h2);
      tick();
      ei = OVR_IRQ;
      vectors++; if (bus.irq !== ei) begin miscompares++; $display("FAIL ovr_irq: got %b want %b", bus.irq, ei); end
      rd(1'b0, d); e = exp_status();
      vectors++; if (d !== e || d !== 32'h6) begin miscompares++; $display("FAIL ovr_empty_status: got %h want %h", d, 32'h6); end
      wr_ctrl(32'h6);
      rd(1'b0, d); e = exp_status();
      vectors++; if (d !== e || d !== 32'h2) begin miscompares++; $display("FAIL ovr_w1c: got %h want %h", d, 32'h2); end
      vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL ovr_irq_clear: got %b want 0", bus.irq); end
   endtask

   task automatic test_async_reset();
      logic [31:0] d, e;
      wr_ctrl(32'h2);
      for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
      rd(1'b0, d); e = exp_status();
      vectors++; if (d !== e || d !== 32'h503) begin miscompares++; $display("FAIL pre_reset_status: got %h want %h", d, 32'h503); end
      #3 reset_n = 1'b0;
      exp_q.delete();
      m_ie = 0; m_ovr = 0;
      bus.en = 1'b1; bus.wr = 1'b0; bus.addr = 1'b0;
      #1;
      vectors++; if (bus.data_out !== 32'h0) begin miscompares++; $display("FAIL async_status: got %h want %h", bus.data_out, 32'h0); end
      vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL async_irq: got %b want 0", bus.irq); end
      bus.en = 1'b0;
      #2 reset_n = 1'b1;
      tick();
      push_byte(8'h5A);
      rd(1'b1, d); e = {24'h0, exp_q.pop_front()};
      vectors++; if (d !== e) begin miscompares++; $display("FAIL after_reset_data: got %h want %h", d, e); end
      rd(1'b0, d); e = exp_status();
      vectors++; if (d !== e) begin miscompares++; $display("FAIL after_reset_status: got %h want %h", d, e); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_overflow();
      test_full_simul();
      test_irq();
      test_overrun();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
